// File: rtl/arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e    : arbiter FSM state encoding
//   STARVE_MAX_DEF : default number of back-to-back data grants while the
//                    instruction port waits
//   TIMEOUT_DEF    : default ack-wait limit, in cycles, for timeout builds
//   cnt_width()    : bits needed to hold a count from 0 up to a maximum
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  localparam int STARVE_MAX_DEF = 3;
  localparam int TIMEOUT_DEF    = 15;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every non-clock/reset signal of the memory port arbiter.
//   requester side : i_req_i/i_addr_i -> i_done_o/i_rdata_o/i_stall_o
//                    d_req_i/d_we_i/d_addr_i/d_wdata_i -> d_done_o/d_rdata_o/d_stall_o
//   memory side    : mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o -> mem_ack_i/mem_rdata_i
//   status         : err_o
// Modports: slave is the arbiter itself, master is whatever drives it
// (pipeline stages plus the memory).
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              i_req_i;
  logic [DATA_W-1:0] i_addr_i;
  logic              i_done_o;
  logic [DATA_W-1:0] i_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [DATA_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_done_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              i_stall_o;
  logic              d_stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              err_o;

  modport slave (
    input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_ack_i, mem_rdata_i,
    output i_done_o, i_rdata_o, d_done_o, d_rdata_o, i_stall_o, d_stall_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

  modport master (
    output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_ack_i, mem_rdata_i,
    input  i_done_o, i_rdata_o, d_done_o, d_rdata_o, i_stall_o, d_stall_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );
endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants given while the instruction port waits.
//   clk_i, rst_i : clock, async active-low reset
//   inc          : count one more starved grant (holds at MAX)
//   clr          : clear to zero (wins over inc)
//   at_max       : count has reached MAX
//   cnt          : current count
module arb_starve_counter
  import arb_pkg::*;
#(
  parameter  int MAX = STARVE_MAX_DEF,
  localparam int CW  = cnt_width(MAX)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc,
  input  logic          clr,
  output logic          at_max,
  output logic [CW-1:0] cnt
);

  assign at_max = (cnt == CW'(MAX));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared
// single-port memory. Data wins ties unless the instruction port has
// already been passed over STARVE_MAX times in a row.
//   clk_i, rst_i : clock, async active-low reset
//   bus          : mem_port_arbiter_if.slave (requesters, memory, err_o)
// Optional build macro ARB_TIMEOUT_EN: abandons a grant after TIMEOUT
// cycles without ack and sets the sticky err_o; otherwise err_o is 0 and
// a grant waits for ack forever.
//
// state   | meaning
// IDLE    | no access; pick next requester
// GRANT_I | instruction read on the memory bus, waiting for ack
// GRANT_D | data read/write on the memory bus, waiting for ack
// DONE    | one-cycle done pulse to the served port
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus
);

  localparam int SCW = cnt_width(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic              sel_d_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;
  logic              enter_i, enter_d, in_grant, timeout_hit;
  logic              at_max;
  logic [SCW-1:0]    starve_cnt;

  assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);

  always_comb begin
    state_d = state_q;
    enter_i = 1'b0;
    enter_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_req_i && !(bus.i_req_i && at_max)) begin
          state_d = GRANT_D;
          enter_d = 1'b1;
        end else if (bus.i_req_i) begin
          state_d = GRANT_I;
          enter_i = 1'b1;
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_ack_i) state_d = DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      sel_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // Requester inputs are sampled only here, so later changes cannot
      // disturb the access already on the memory bus.
      if (enter_i || enter_d) begin
        sel_d_q <= enter_d;
        we_q    <= enter_d && bus.d_we_i;
        addr_q  <= enter_d ? bus.d_addr_i : bus.i_addr_i;
        wdata_q <= enter_d ? bus.d_wdata_i : '0;
      end
      if (in_grant && bus.mem_ack_i) begin
        if (!sel_d_q) i_rdata_q <= bus.mem_rdata_i;
        else if (!we_q) d_rdata_q <= bus.mem_rdata_i;
      end
    end
  end

  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc    (enter_d && bus.i_req_i),
    .clr    (enter_i),
    .at_max (at_max),
    .cnt    (starve_cnt)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int WCW = cnt_width(TIMEOUT);
  logic [WCW-1:0] wait_q;
  logic           err_q;

  // Fires on the last of TIMEOUT ack-less grant cycles.
  assign timeout_hit = in_grant && !bus.mem_ack_i && (wait_q == WCW'(TIMEOUT - 1));
  assign bus.err_o   = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (enter_i || enter_d) wait_q <= '0;
      else if (in_grant && !bus.mem_ack_i) wait_q <= wait_q + 1'b1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign bus.err_o      = 1'b0;
`endif

  assign bus.mem_req_o   = in_grant;
  assign bus.mem_we_o    = in_grant && we_q;
  assign bus.mem_addr_o  = in_grant ? addr_q : '0;
  assign bus.mem_wdata_o = in_grant ? wdata_q : '0;
  assign bus.i_done_o    = (state_q == DONE) && !sel_d_q;
  assign bus.d_done_o    = (state_q == DONE) && sel_d_q;
  assign bus.i_rdata_o   = i_rdata_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.i_stall_o   = bus.i_req_i && !bus.i_done_o;
  assign bus.d_stall_o   = bus.d_req_i && !bus.d_done_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table for
// the single-port sequences, plus hand-written starvation, input-change,
// reset-abort and ack-wait/timeout sequences.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam logic [31:0] IA   = 32'h0000_0040;
  localparam logic [31:0] DA   = 32'h0000_0100;
  localparam logic [31:0] WD   = 32'h1234_5678;
  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] R1   = 32'hA5A5_0001;
  localparam logic [31:0] R2   = 32'h0000_1111;
  localparam logic [31:0] FF   = 32'hFFFF_FFFF;
  localparam int          NV   = 19;

  // in_f = {i_req, d_req, d_we, ack}
  // ex_f = {mem_req, mem_we, i_done, d_done, i_stall, d_stall}
  typedef struct {
    logic [3:0]  in_f;
    logic [31:0] d_wdata;
    logic [31:0] rdata;
    logic [5:0]  ex_f;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i;
  int   n_assert = 0;
  int   n_fail = 0;
  int   g;
  int   gc;
  logic done_seen;
  logic [3:0] seq_d;
  vec_t vecs [NV];

  mem_port_arbiter_if #(.DATA_W(32)) bus ();

  mem_port_arbiter #(.DATA_W(32), .STARVE_MAX(3), .TIMEOUT(15)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{4'b1000, 32'h0, 32'h0,        6'b000010, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{4'b1000, 32'h0, 32'h0,        6'b100010, IA,    32'h0, 32'h0, 32'h0};
    vecs[2]  = '{4'b1000, 32'h0, 32'h0,        6'b100010, IA,    32'h0, 32'h0, 32'h0};
    vecs[3]  = '{4'b1001, 32'h0, BEEF,         6'b100010, IA,    32'h0, 32'h0, 32'h0};
    vecs[4]  = '{4'b1001, 32'h0, 32'h7777,     6'b001000, 32'h0, 32'h0, BEEF,  32'h0};
    vecs[5]  = '{4'b0001, 32'h0, 32'h5555,     6'b000000, 32'h0, 32'h0, BEEF,  32'h0};
    vecs[6]  = '{4'b0000, 32'h0, 32'h0,        6'b000000, 32'h0, 32'h0, BEEF,  32'h0};
    vecs[7]  = '{4'b1100, 32'h0, 32'h0,        6'b000011, 32'h0, 32'h0, BEEF,  32'h0};
    vecs[8]  = '{4'b1101, 32'h0, R1,           6'b100011, DA,    32'h0, BEEF,  32'h0};
    vecs[9]  = '{4'b1100, 32'h0, 32'h0,        6'b000110, 32'h0, 32'h0, BEEF,  R1};
    vecs[10] = '{4'b1000, 32'h0, 32'h0,        6'b000010, 32'h0, 32'h0, BEEF,  R1};
    vecs[11] = '{4'b1001, 32'h0, R2,           6'b100010, IA,    32'h0, BEEF,  R1};
    vecs[12] = '{4'b1000, 32'h0, 32'h0,        6'b001000, 32'h0, 32'h0, R2,    R1};
    vecs[13] = '{4'b0000, 32'h0, 32'h0,        6'b000000, 32'h0, 32'h0, R2,    R1};
    vecs[14] = '{4'b0110, WD,    32'h0,        6'b000001, 32'h0, 32'h0, R2,    R1};
    vecs[15] = '{4'b0110, WD,    32'h0,        6'b110001, DA,    WD,    R2,    R1};
    vecs[16] = '{4'b0111, WD,    FF,           6'b110001, DA,    WD,    R2,    R1};
    vecs[17] = '{4'b0110, WD,    32'h0,        6'b000100, 32'h0, 32'h0, R2,    R1};
    vecs[18] = '{4'b0000, 32'h0, 32'h0,        6'b000000, 32'h0, 32'h0, R2,    R1};

    // Reset state, with requests pending.
    rst_i = 1'b0;
    bus.i_req_i = 1'b1;  bus.i_addr_i = IA;
    bus.d_req_i = 1'b1;  bus.d_we_i = 1'b0;
    bus.d_addr_i = DA;   bus.d_wdata_i = 32'h0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst mem_req", {31'h0, bus.mem_req_o}, 32'h0);
    chk("rst i_done", {31'h0, bus.i_done_o}, 32'h0);
    chk("rst d_done", {31'h0, bus.d_done_o}, 32'h0);
    chk("rst i_rdata", bus.i_rdata_o, 32'h0);
    chk("rst d_rdata", bus.d_rdata_o, 32'h0);
    chk("rst err", {31'h0, bus.err_o}, 32'h0);
    chk("rst state", 32'(dut.state_q), 32'(IDLE));
    chk("rst starve_cnt", 32'(dut.starve_cnt), 32'h0);
    bus.i_req_i = 1'b0;
    bus.d_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;

    // Cycle-by-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      {bus.i_req_i, bus.d_req_i, bus.d_we_i, bus.mem_ack_i} = vecs[i].in_f;
      bus.d_wdata_i   = vecs[i].d_wdata;
      bus.mem_rdata_i = vecs[i].rdata;
      #1;
      chk($sformatf("row%0d mem_req", i), {31'h0, bus.mem_req_o}, {31'h0, vecs[i].ex_f[5]});
      if (vecs[i].ex_f[5]) begin
        chk($sformatf("row%0d mem_we", i), {31'h0, bus.mem_we_o}, {31'h0, vecs[i].ex_f[4]});
        chk($sformatf("row%0d mem_addr", i), bus.mem_addr_o, vecs[i].e_addr);
        chk($sformatf("row%0d mem_wdata", i), bus.mem_wdata_o, vecs[i].e_wdata);
      end
      chk($sformatf("row%0d i_done", i), {31'h0, bus.i_done_o}, {31'h0, vecs[i].ex_f[3]});
      chk($sformatf("row%0d d_done", i), {31'h0, bus.d_done_o}, {31'h0, vecs[i].ex_f[2]});
      chk($sformatf("row%0d i_stall", i), {31'h0, bus.i_stall_o}, {31'h0, vecs[i].ex_f[1]});
      chk($sformatf("row%0d d_stall", i), {31'h0, bus.d_stall_o}, {31'h0, vecs[i].ex_f[0]});
      chk($sformatf("row%0d i_rdata", i), bus.i_rdata_o, vecs[i].e_irdata);
      chk($sformatf("row%0d d_rdata", i), bus.d_rdata_o, vecs[i].e_drdata);
      chk($sformatf("row%0d err", i), {31'h0, bus.err_o}, 32'h0);
    end

    // Starvation: both ports request continuously, memory acks at once.
    g = 0;
    seq_d = 4'b0;
    bus.d_wdata_i = 32'h0;
    for (int k = 0; k < 60 && g < 4; k++) begin
      @(negedge clk);
      bus.i_req_i = 1'b1;
      bus.d_req_i = 1'b1;
      bus.d_we_i = 1'b0;
      bus.mem_ack_i = bus.mem_req_o;
      bus.mem_rdata_i = 32'(g);
      if (bus.mem_req_o) begin
        seq_d[g] = (bus.mem_addr_o == DA);
        g++;
      end
    end
    chk("starve grant count", 32'(g), 32'd4);
    chk("starve grant order", {28'h0, seq_d}, {28'h0, 4'b0111});
    @(negedge clk);
    bus.i_req_i = 1'b0; bus.d_req_i = 1'b0; bus.mem_ack_i = 1'b0;
    #1;
    chk("starve i_done", {31'h0, bus.i_done_o}, 32'h1);
    chk("starve cnt cleared", 32'(dut.starve_cnt), 32'h0);
    chk("starve i_rdata", bus.i_rdata_o, 32'd3);

    // Requester inputs change mid-grant.
    @(negedge clk);
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = DA; bus.d_wdata_i = WD;
    @(negedge clk);
    bus.d_addr_i = 32'h200; bus.d_we_i = 1'b0; bus.d_wdata_i = 32'hCAFE; bus.i_req_i = 1'b1;
    #1;
    chk("hold mem_addr", bus.mem_addr_o, DA);
    chk("hold mem_we", {31'h0, bus.mem_we_o}, 32'h1);
    chk("hold mem_wdata", bus.mem_wdata_o, WD);
    @(negedge clk);
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h9999;
    #1;
    chk("hold mem_addr 2", bus.mem_addr_o, DA);
    @(negedge clk);
    bus.mem_ack_i = 1'b0; bus.d_req_i = 1'b0; bus.i_req_i = 1'b0;
    bus.d_addr_i = DA; bus.d_we_i = 1'b0; bus.d_wdata_i = 32'h0;
    #1;
    chk("hold d_done", {31'h0, bus.d_done_o}, 32'h1);
    chk("hold write keeps d_rdata", bus.d_rdata_o, 32'd2);

    // Reset during GRANT_D aborts the access.
    @(negedge clk);
    bus.d_req_i = 1'b1;
    @(negedge clk);
    #1;
    chk("abort granted", {31'h0, bus.mem_req_o}, 32'h1);
    rst_i = 1'b0;
    #1;
    chk("abort mem_req in reset", {31'h0, bus.mem_req_o}, 32'h0);
    chk("abort state in reset", 32'(dut.state_q), 32'(IDLE));
    chk("abort d_rdata cleared", bus.d_rdata_o, 32'h0);
    @(negedge clk);
    bus.d_req_i = 1'b0;
    rst_i = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      done_seen = done_seen | bus.d_done_o | bus.i_done_o | bus.mem_req_o;
    end
    chk("abort no done/req after release", {31'h0, done_seen}, 32'h0);
    chk("abort state idle", 32'(dut.state_q), 32'(IDLE));

    // Grant with no ack.
    @(negedge clk);
    bus.i_req_i = 1'b1;
    gc = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      done_seen = done_seen | bus.i_done_o;
      if (bus.mem_req_o) gc++;
      else if (gc > 0) break;
    end
`ifdef ARB_TIMEOUT_EN
    bus.i_req_i = 1'b0;
    chk("timeout grant cycles", 32'(gc), 32'd15);
    chk("timeout err", {31'h0, bus.err_o}, 32'h1);
    chk("timeout state idle", 32'(dut.state_q), 32'(IDLE));
    chk("timeout no done", {31'h0, done_seen}, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("timeout err sticky", {31'h0, bus.err_o}, 32'h1);
`else
    chk("wait grant cycles", 32'(gc), 32'd40);
    chk("wait err", {31'h0, bus.err_o}, 32'h0);
    chk("wait no done", {31'h0, done_seen}, 32'h0);
    @(negedge clk);
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h4242;
    @(negedge clk);
    bus.mem_ack_i = 1'b0; bus.i_req_i = 1'b0;
    #1;
    chk("wait late i_done", {31'h0, bus.i_done_o}, 32'h1);
    chk("wait late i_rdata", bus.i_rdata_o, 32'h4242);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
